// File: rtl/div_arb_pkg.sv
// Shared types for the divider-sharing front end: FSM states and the
// error code returned to a requester alongside its quotient/remainder.
package div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAP,
    RESP
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE = 2'd0;
  localparam err_t ERR_OV   = 2'd1;
  localparam err_t ERR_DBZ  = 2'd2;
  localparam err_t ERR_TMO  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that was not served last wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic lastServed_i,
  output logic grantValid_o,
  output logic grantId_o
);

  always_comb begin
    grantValid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      grantId_o = ~lastServed_i;
    end else begin
      grantId_o = req1_i;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one sequential divider between two level-request ports, returning
// quotient/remainder/error per port and resetting the divider if it hangs.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NW  = 10,
  parameter int DW  = 5,
  parameter int OW  = 5,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [NW-1:0] a0,
  input  logic [NW-1:0] a1,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] b1,
  output logic          ack0,
  output logic          ack1,
  output logic [OW-1:0] q0,
  output logic [OW-1:0] q1,
  output logic [OW-1:0] r0,
  output logic [OW-1:0] r1,
  output logic [1:0]    err0,
  output logic [1:0]    err1,
  output logic          div_start,
  output logic [NW-1:0] div_dividend,
  output logic [DW-1:0] div_divisor,
  input  logic          div_done,
  input  logic [OW-1:0] div_data,
  input  logic          div_ov,
  input  logic          div_dbz,
  output logic          div_rst,
  output logic          busy,
  output logic          grant_id
);

  localparam int WDW = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

  state_t         state_q, state_d;
  logic           grantId_q;
  logic           lastServed_q;
  logic [NW-1:0]  dividend_q;
  logic [DW-1:0]  divisor_q;
  logic [OW-1:0]  quot_q [2];
  logic [OW-1:0]  rem_q  [2];
  err_t           err_q  [2];
  logic [WDW-1:0] wdCnt_q;

  logic arbValid;
  logic arbId;
  logic wdExpire;

  rr_arb2 uArb (
    .req0_i       (req0),
    .req1_i       (req1),
    .lastServed_i (lastServed_q),
    .grantValid_o (arbValid),
    .grantId_o    (arbId)
  );

  assign wdExpire = (wdCnt_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider error pulses take precedence over a done word; the watchdog only fires on a silent cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arbValid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (div_ov || div_dbz) begin
          state_d = RESP;
        end else if (div_done) begin
          state_d = CAP;
        end else if (wdExpire) begin
          state_d = RESP;
        end
      end
      CAP:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    div_rst   = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      ISSUE: div_start = 1'b1;
      WAIT:  div_rst = wdExpire && !div_ov && !div_dbz && !div_done;
      RESP: begin
        ack0 = ~grantId_q;
        ack1 = grantId_q;
      end
      default: ;
    endcase
  end

  // Results land directly in the granted port's registers; the other port's stay untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      grantId_q    <= 1'b0;
      lastServed_q <= 1'b1;
      dividend_q   <= '0;
      divisor_q    <= '0;
      wdCnt_q      <= '0;
      quot_q[0]    <= '0;
      quot_q[1]    <= '0;
      rem_q[0]     <= '0;
      rem_q[1]     <= '0;
      err_q[0]     <= ERR_NONE;
      err_q[1]     <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arbValid) begin
            grantId_q  <= arbId;
            dividend_q <= arbId ? a1 : a0;
            divisor_q  <= arbId ? b1 : b0;
          end
        end
        ISSUE: wdCnt_q <= '0;
        WAIT: begin
          wdCnt_q <= wdCnt_q + WDW'(1);
          if (div_dbz) begin
            quot_q[grantId_q] <= '0;
            rem_q[grantId_q]  <= '0;
            err_q[grantId_q]  <= ERR_DBZ;
          end else if (div_ov) begin
            quot_q[grantId_q] <= '0;
            rem_q[grantId_q]  <= '0;
            err_q[grantId_q]  <= ERR_OV;
          end else if (div_done) begin
            quot_q[grantId_q] <= div_data;
            err_q[grantId_q]  <= ERR_NONE;
          end else if (wdExpire) begin
            quot_q[grantId_q] <= '0;
            rem_q[grantId_q]  <= '0;
            err_q[grantId_q]  <= ERR_TMO;
          end
        end
        CAP: begin
          if (div_done) begin
            rem_q[grantId_q] <= div_data;
          end else begin
            quot_q[grantId_q] <= '0;
            rem_q[grantId_q]  <= '0;
            err_q[grantId_q]  <= ERR_TMO;
          end
        end
        RESP: lastServed_q <= grantId_q;
        default: ;
      endcase
    end
  end

  assign q0           = quot_q[0];
  assign q1           = quot_q[1];
  assign r0           = rem_q[0];
  assign r1           = rem_q[1];
  assign err0         = err_q[0];
  assign err1         = err_q[1];
  assign grant_id     = grantId_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: a behavioural divider model answers
// each start, directed requests push hand-computed results, a monitor checks acks.
module tb_div_share_arbiter;

  localparam int NW  = 10;
  localparam int DW  = 5;
  localparam int OW  = 5;
  localparam int TMO = 255;

  localparam int M_NORMAL = 0;
  localparam int M_OV     = 1;
  localparam int M_DBZ    = 2;
  localparam int M_BOTH   = 3;
  localparam int M_HANG   = 4;

  typedef struct {
    int port;
    int q;
    int r;
    int err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic [NW-1:0] a0, a1;
  logic [DW-1:0] b0, b1;
  logic          ack0, ack1;
  logic [OW-1:0] q0, q1, r0, r1;
  logic [1:0]    err0, err1;
  logic          div_start;
  logic [NW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_done;
  logic [OW-1:0] div_data;
  logic          div_ov, div_dbz;
  logic          div_rst;
  logic          busy;
  logic          grant_id;

  exp_t expQ[$];
  int   nVec = 0;
  int   nMis = 0;
  int   nAck = 0;
  int   cyc = 0;
  int   mode = M_NORMAL;
  int   startCyc = 0;
  int   expAckCyc = 0;
  int   rstPulses = 0;
  int   shQ[2] = '{0, 0};
  int   shR[2] = '{0, 0};
  int   shE[2] = '{0, 0};

  div_share_arbiter #(.NW(NW), .DW(DW), .OW(OW), .TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .a0           (a0),
    .a1           (a1),
    .b0           (b0),
    .b1           (b1),
    .ack0         (ack0),
    .ack1         (ack1),
    .q0           (q0),
    .q1           (q1),
    .r0           (r0),
    .r1           (r1),
    .err0         (err0),
    .err1         (err1),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_data     (div_data),
    .div_ov       (div_ov),
    .div_dbz      (div_dbz),
    .div_rst      (div_rst),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider model: answers two cycles after start according to the current mode
  initial begin
    int m;
    int dvd;
    int dvs;
    div_done = 1'b0;
    div_data = '0;
    div_ov   = 1'b0;
    div_dbz  = 1'b0;
    forever begin
      @(negedge clk);
      if (div_start && !rst) begin
        startCyc = cyc;
        m   = mode;
        dvd = int'(div_dividend);
        dvs = int'(div_divisor);
        @(posedge clk);
        @(posedge clk);
        #1;
        case (m)
          M_NORMAL: begin
            div_done = 1'b1;
            div_data = OW'(dvd / dvs);
            @(posedge clk);
            #1;
            div_data  = OW'(dvd % dvs);
            expAckCyc = cyc + 1;
            @(posedge clk);
            #1;
            div_done = 1'b0;
            div_data = '0;
          end
          M_OV, M_DBZ, M_BOTH: begin
            div_ov    = (m == M_OV) || (m == M_BOTH);
            div_dbz   = (m == M_DBZ) || (m == M_BOTH);
            expAckCyc = cyc + 1;
            @(posedge clk);
            #1;
            div_ov  = 1'b0;
            div_dbz = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Watchdog reset must come on the TMO-th WAIT cycle, with the ack one cycle later
  always @(negedge clk) begin
    if (!rst && div_rst) begin
      rstPulses++;
      checkOutput("div_rst timing", cyc, startCyc + TMO);
      expAckCyc = cyc + 1;
    end
  end

  // Monitor: every ack pops one expectation; the other port must hold its results
  always @(negedge clk) begin
    exp_t e;
    int   p;
    int   o;
    if (!rst && (ack0 || ack1)) begin
      nAck++;
      checkOutput("single ack", int'(ack0) + int'(ack1), 1);
      p = ack1 ? 1 : 0;
      o = 1 - p;
      if (expQ.size() == 0) begin
        checkOutput("unexpected ack port", p, -1);
      end else begin
        e = expQ.pop_front();
        checkOutput("ack port", p, e.port);
        checkOutput("ack latency", cyc, expAckCyc);
        checkOutput("quotient", p ? int'(q1) : int'(q0), e.q);
        checkOutput("remainder", p ? int'(r1) : int'(r0), e.r);
        checkOutput("err code", p ? int'(err1) : int'(err0), e.err);
        checkOutput("grant_id", int'(grant_id), e.port);
        checkOutput("other q held", o ? int'(q1) : int'(q0), shQ[o]);
        checkOutput("other r held", o ? int'(r1) : int'(r0), shR[o]);
        checkOutput("other err held", o ? int'(err1) : int'(err0), shE[o]);
        shQ[p] = e.q;
        shR[p] = e.r;
        shE[p] = e.err;
      end
    end
  end

  task automatic waitAcks(input int target, input int limit);
    int i;
    i = 0;
    while (nAck < target && i < limit) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (nAck < target) checkOutput("ack wait timeout", nAck, target);
  endtask

  task automatic applyStimulus(input int port, input int a, input int b, input int m,
                               input int eq, input int er, input int ee, input int limit);
    exp_t e;
    e.port = port;
    e.q    = eq;
    e.r    = er;
    e.err  = ee;
    mode   = m;
    expQ.push_back(e);
    if (port == 0) begin
      a0   = NW'(a);
      b0   = DW'(b);
      req0 = 1'b1;
    end else begin
      a1   = NW'(a);
      b1   = DW'(b);
      req1 = 1'b1;
    end
    waitAcks(nAck + 1, limit);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " ack0"}, int'(ack0), 0);
    checkOutput({tag, " ack1"}, int'(ack1), 0);
    checkOutput({tag, " q0"}, int'(q0), 0);
    checkOutput({tag, " r0"}, int'(r0), 0);
    checkOutput({tag, " err0"}, int'(err0), 0);
    checkOutput({tag, " q1"}, int'(q1), 0);
    checkOutput({tag, " err1"}, int'(err1), 0);
    checkOutput({tag, " div_start"}, int'(div_start), 0);
    checkOutput({tag, " div_rst"}, int'(div_rst), 0);
    checkOutput({tag, " div_dividend"}, int'(div_dividend), 0);
    checkOutput({tag, " grant_id"}, int'(grant_id), 0);
  endtask

  initial begin
    exp_t e;
    int   base;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0   = '0;
    a1   = '0;
    b0   = '0;
    b1   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 checkResetState("reset");

    // Tie from reset: port 0 first, then strict alternation while both stay asserted
    mode = M_NORMAL;
    base = nAck;
    for (int i = 0; i < 4; i++) begin
      e.port = i % 2;
      e.q    = (i % 2 == 0) ? 14 : 8;
      e.r    = 2;
      e.err  = 0;
      expQ.push_back(e);
    end
    a0 = NW'(100);
    b0 = DW'(7);
    a1 = NW'(50);
    b1 = DW'(6);
    req0 = 1'b1;
    req1 = 1'b1;
    waitAcks(base + 3, 100);
    req0 = 1'b0;
    waitAcks(base + 4, 50);
    req1 = 1'b0;

    applyStimulus(0, 100, 7, M_NORMAL, 14, 2, 0, 50);
    applyStimulus(1, 200, 0, M_DBZ, 0, 0, 2, 50);
    applyStimulus(0, 1000, 3, M_OV, 0, 0, 1, 50);
    applyStimulus(0, 1000, 3, M_BOTH, 0, 0, 2, 50);
    applyStimulus(1, 31, 5, M_NORMAL, 6, 1, 0, 50);

    rstPulses = 0;
    applyStimulus(0, 100, 7, M_HANG, 0, 0, 3, 400);
    checkOutput("div_rst pulse count", rstPulses, 1);

    // Reset while the divider is silent: transaction abandoned, no ack afterwards
    mode = M_HANG;
    a0   = NW'(100);
    b0   = DW'(7);
    req0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy before reset", int'(busy), 1);
    rst  = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    shQ = '{0, 0};
    shR = '{0, 0};
    shE = '{0, 0};
    #1 checkResetState("mid reset");
    checkOutput("mid reset r1", int'(r1), 0);
    base = nAck;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("idle after reset", int'(busy), 0);
    checkOutput("no ack after reset", nAck, base);

    applyStimulus(0, 100, 7, M_NORMAL, 14, 2, 0, 50);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending expectations", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Two-port front end that shares the single sequential divider unit between two requesters. Accepts level requests carrying dividend/divisor and arbitrates round-robin. Drives the divider's start/operand interface and collects its two-cycle result burst (quotient, then remainder) or its error pulse. Returns quotient, remainder and an error code to the winning port with a one-cycle ack. Includes a watchdog that resets a hung divider.

## Interface
- NW, 10, dividend width
- DW, 5, divisor width
- OW, 5, result word width (quotient and remainder each)
- TMO, 255, watchdog limit in cycles spent in WAIT
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0, req1  in  1  level request; held with operands stable until matching ack
- a0, a1  in  NW  dividend per port
- b0, b1  in  DW  divisor per port
- ack0, ack1  out  1  one-cycle completion pulse
- q0, q1  out  OW  quotient; valid on ack, held until that port's next ack
- r0, r1  out  OW  remainder; same validity as q
- err0, err1  out  2  error code; same validity (0 none, 1 OV, 2 DBZ, 3 timeout)
- div_start  out  1  one-cycle start to divider
- div_dividend  out  NW  operand to divider; held from ISSUE through end of transaction
- div_divisor  out  DW  operand to divider; same hold
- div_done  in  1  high two consecutive cycles: word 0 = quotient, word 1 = remainder
- div_data  in  OW  divider output word, qualified by div_done
- div_ov, div_dbz  in  1  single-cycle error pulses; no div_done follows
- div_rst  out  1  one-cycle divider reset on watchdog expiry
- busy  out  1  high in every state except IDLE
- grant_id  out  1  port owning the current transaction

## Operation
- States:
  - IDLE: if any req, latch winner into grant_id and go ISSUE.
  - ISSUE: div_start=1; go WAIT.
  - WAIT: first div_done: capture div_data into the granted port's q, go CAP.
    - div_ov: err=1, go RESP. div_dbz: err=2, go RESP. Both in the same cycle: err=2 (DBZ wins).
    - Watchdog reaches TMO: div_rst=1, err=3, go RESP.
  - CAP: div_data into r (div_done must still be high; if low, err=3 and r=0); go RESP.
  - RESP: ack of the granted port=1, update last-served; go IDLE.
- Arbitration: single request wins directly. Both requesting: the port not last served wins. last_served resets to 1, so port 0 wins the first tie.
- On error, q and r of the granted port are written 0.
- Once granted, the transaction completes and acks even if req drops; operands remain latched, not re-sampled.
- Ungranted port's q/r/err never change during another port's transaction.
- Watchdog counter clears on entering WAIT and increments each WAIT cycle. Expiry when count == TMO-1, i.e. TMO WAIT cycles.
- div_ov/div_dbz/div_done outside WAIT/CAP are ignored.

## Timing
- Request seen in IDLE at cycle t: ISSUE (div_start) at t+1, WAIT from t+2.
- Result: done word 0 at cycle d, word 1 at d+1, ack at d+2. q/r/err visible at d+2 and held after.
- Error pulse at cycle e: ack at e+1.
- IDLE re-arbitrates the cycle after RESP; back-to-back service has 1 idle cycle between ack and next div_start.
- Port must deassert req the cycle after ack, else it is re-served (with fairness applied).
- Reset values: all outputs 0, state IDLE, last_served=1, watchdog 0. Reset mid-transaction abandons it: no ack, no div_rst; the divider shares rst.

## Structure
- Package div_arb_pkg: state enum (IDLE, ISSUE, WAIT, CAP, RESP), error constants ERR_NONE/ERR_OV/ERR_DBZ/ERR_TMO, 2-bit err type.
- Sub-module rr_arb2: combinational 2-way round-robin picker (req0, req1, last_served -> grant valid, grant_id).
- Top holds FSM, operand mux/latch, per-port result registers, watchdog.

## Test plan
- req0, a0=100, b0=7; bench model gives done words 14, 2 -> ack0 at d+2, q0=14, r0=2, err0=0; q1/r1 untouched.
- req0 and req1 both rise same cycle (100/7, 50/6) -> port 0 served first (q0=14, r0=2), then port 1 (q1=8, r1=2). Both held again -> service alternates 1, 0.
- b1=0, model pulses div_dbz -> ack1 one cycle later, err1=2, q1=r1=0, no div_done consumed.
- a0=1000, b0=3, model pulses div_ov -> err0=1. Same cycle ov+dbz -> err0=2.
- Model never responds, TMO=255 -> div_rst pulse after 255 WAIT cycles, ack0 next cycle with err0=3.
- rst asserted during WAIT -> next cycle all outputs 0, busy=0, no ack. Fresh req0 afterwards -> normal service with correct results.
